// File: rtl/wtu_lvl1_seq.sv
// Sequencer that feeds WTU level 1 with sample pairs and load strobes.
// It also captures the level-1 {hs,ls} result into a valid/ready coefficient stream.
module wtu_lvl1_seq #(
  parameter int OUT_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic [23:0]      lvl_in,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_o,
  input  logic [47:0]      lvl_out,
  output logic [23:0]      coef_hs,
  output logic [23:0]      coef_ls,
  output logic             coef_valid,
  input  logic             coef_ready,
  output logic [CNT_W-1:0] pair_cnt
);

  localparam logic [3:0] LP_LAT = 4'(OUT_LAT);

  typedef enum logic [2:0] {S_A, S_B, S_O, S_W, S_C} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_wait;
  logic [3:0]       w_wait_nxt;
  logic             w_accept;
  logic             w_capture;
  logic             w_ld_a_nxt;
  logic             w_ld_b_nxt;
  logic             w_ld_o_nxt;
  logic [23:0]      r_lvl_in;
  logic             r_ld_a;
  logic             r_ld_b;
  logic             r_ld_o;
  logic [23:0]      r_coef_hs;
  logic [23:0]      r_coef_ls;
  logic             r_coef_valid;
  logic [CNT_W-1:0] r_pair_cnt;

  assign sample_ready = (r_state == S_A) || (r_state == S_B);
  assign w_accept     = sample_valid && sample_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_A;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_ld_a_nxt  = 1'b0;
    w_ld_b_nxt  = 1'b0;
    w_ld_o_nxt  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_A: begin
        if (w_accept) begin
          w_ld_a_nxt  = 1'b1;
          w_state_nxt = S_B;
        end
      end
      S_B: begin
        if (w_accept) begin
          w_ld_b_nxt  = 1'b1;
          w_state_nxt = S_O;
        end
      end
      S_O: begin
        w_ld_o_nxt  = 1'b1;
        w_wait_nxt  = LP_LAT;
        w_state_nxt = S_W;
      end
      S_W: begin
        // Leaving at cnt==1 lands S_C exactly OUT_LAT cycles after the ld_o cycle.
        w_wait_nxt = r_wait - 4'd1;
        if (r_wait <= 4'd1) begin
          w_state_nxt = S_C;
        end
      end
      S_C: begin
        if (!r_coef_valid || coef_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = S_A;
        end
      end
      default: w_state_nxt = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lvl_in     <= 24'd0;
      r_ld_a       <= 1'b0;
      r_ld_b       <= 1'b0;
      r_ld_o       <= 1'b0;
      r_coef_hs    <= 24'd0;
      r_coef_ls    <= 24'd0;
      r_coef_valid <= 1'b0;
      r_pair_cnt   <= '0;
    end else begin
      r_ld_a <= w_ld_a_nxt;
      r_ld_b <= w_ld_b_nxt;
      r_ld_o <= w_ld_o_nxt;
      if (w_accept) begin
        r_lvl_in <= sample_in;
      end
      // A capture wins over a same-cycle handshake, so valid stays high with new data.
      if (w_capture) begin
        r_coef_hs    <= lvl_out[47:24];
        r_coef_ls    <= lvl_out[23:0];
        r_coef_valid <= 1'b1;
        r_pair_cnt   <= r_pair_cnt + CNT_W'(1);
      end else if (r_coef_valid && coef_ready) begin
        r_coef_valid <= 1'b0;
      end
    end
  end

  assign lvl_in     = r_lvl_in;
  assign ld_a       = r_ld_a;
  assign ld_b       = r_ld_b;
  assign ld_o       = r_ld_o;
  assign coef_hs    = r_coef_hs;
  assign coef_ls    = r_coef_ls;
  assign coef_valid = r_coef_valid;
  assign pair_cnt   = r_pair_cnt;

endmodule
